// File: rtl/alu_pkg.sv
// Shared encodings, FSM state type and lane-width helper for the pipelined lane ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SR  = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SL  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] VEC_CHAR   = 2'b00;
  localparam logic [1:0] VEC_HALF   = 2'b01;
  localparam logic [1:0] VEC_FULL   = 2'b10;
  localparam logic [1:0] VEC_DOUBLE = 2'b11;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Lane width in bits for a lane mode at word width w.
  function automatic int unsigned lane_bits(input logic [1:0] vec, input int unsigned w);
    int unsigned lw;
    case (vec)
      VEC_CHAR: lw = 8;
      VEC_HALF: lw = 16;
      VEC_FULL: lw = w;
      default:  lw = 2 * w;
    endcase
    return lw;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative lane-parallel shift-add multiplier: one multiplier bit per cycle, L cycles per product.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_run,
  input  logic [1:0]         i_vec,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [2*WIDTH-1:0] i_mplier,
  output logic               o_done_c,
  output logic [2*WIDTH-1:0] o_result_c
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DW);

  logic [1:0]           r_vec;
  logic [DW-1:0]        r_mcand;
  logic [DW-1:0]        r_mplier;
  logic [DW-1:0]        r_acc;
  logic [CW-1:0]        r_cnt;
  logic [3:0][DW-1:0]   w_acc_m;
  logic [3:0][DW-1:0]   w_mcand_m;
  logic [3:0][DW-1:0]   w_mplier_m;
  logic [CW-1:0]        w_last;

  // One step per lane; sums and shifted-out bits never cross a lane boundary.
  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned LW = lane_bits(2'(m), WIDTH);
    for (genvar l = 0; l < DW / LW; l++) begin : g_lane
      logic [LW-1:0] w_acc;
      logic [LW-1:0] w_md;
      logic [LW-1:0] w_mr;
      assign w_acc = r_acc[l*LW +: LW];
      assign w_md  = r_mcand[l*LW +: LW];
      assign w_mr  = r_mplier[l*LW +: LW];
      assign w_acc_m[m][l*LW +: LW]    = w_mr[0] ? (w_acc + w_md) : w_acc;
      assign w_mcand_m[m][l*LW +: LW]  = w_md << 1;
      assign w_mplier_m[m][l*LW +: LW] = w_mr >> 1;
    end
  end

  assign w_last     = CW'(lane_bits(r_vec, WIDTH) - 1);
  assign o_done_c   = i_run && (r_cnt == w_last);
  assign o_result_c = w_acc_m[r_vec];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_vec    <= i_vec;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_run) begin
      r_mcand  <= w_mcand_m[r_vec];
      r_mplier <= w_mplier_m[r_vec];
      r_acc    <= w_acc_m[r_vec];
      r_cnt    <= o_done_c ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked lane ALU: single-cycle ops feed a registered output stage; MUL runs on the sequencer.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             form,
  input  logic [1:0]       vec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [2:0]       flags
);

  localparam int unsigned DW = 2 * WIDTH;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_valid;
  logic [DW-1:0]      r_y;
  logic [2:0]         r_flags;

  logic [DW-1:0]      w_x;
  logic [DW-1:0]      w_y;
  logic               w_sub;
  logic [3:0][DW-1:0] w_sum_m;
  logic [3:0][DW-1:0] w_shl_m;
  logic [3:0][DW-1:0] w_shr_m;
  logic [3:0]         w_cout_m;
  logic [DW-1:0]      w_res;
  logic               w_cout;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [DW-1:0]      w_mul_res;
  logic               w_load;
  logic [DW-1:0]      w_load_val;
  logic [2:0]         w_flags_nxt;

  assign w_x   = {A, B};
  assign w_y   = {C, D};
  assign w_sub = (op == OP_SUB);

  // Per-mode lane arithmetic; the top lane of each mode supplies the carry/borrow flag.
  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int unsigned LW = lane_bits(2'(m), WIDTH);
    localparam int unsigned SW = $clog2(LW);
    for (genvar l = 0; l < DW / LW; l++) begin : g_lane
      logic [LW-1:0] w_a;
      logic [LW-1:0] w_b;
      logic [LW-1:0] w_sra;
      logic [SW-1:0] w_sh;
      logic [LW:0]   w_add;
      assign w_a   = w_x[l*LW +: LW];
      assign w_b   = w_y[l*LW +: LW];
      assign w_sh  = w_b[SW-1:0];
      assign w_add = {1'b0, w_a} + {1'b0, (w_sub ? ~w_b : w_b)} + (LW+1)'(w_sub);
      assign w_sra = $signed(w_a) >>> w_sh;
      assign w_sum_m[m][l*LW +: LW] = w_add[LW-1:0];
      assign w_shl_m[m][l*LW +: LW] = w_a << w_sh;
      assign w_shr_m[m][l*LW +: LW] = form ? w_sra : (w_a >> w_sh);
      if (l == DW / LW - 1) begin : g_top
        assign w_cout_m[m] = w_add[LW] ^ w_sub;
      end
    end
  end

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_res  = w_sum_m[vec];
        w_cout = w_cout_m[vec];
      end
      OP_SR:   w_res = w_shr_m[vec];
      OP_SL:   w_res = w_shl_m[vec];
      OP_AND:  w_res = w_x & w_y;
      OP_OR:   w_res = w_x | w_y;
      OP_XOR:  w_res = w_x ^ w_y;
      default: w_res = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_mul_start),
    .i_run      (r_state == BUSY),
    .i_vec      (vec),
    .i_mcand    (w_x),
    .i_mplier   (w_y),
    .o_done_c   (w_mul_done),
    .o_result_c (w_mul_res)
  );

  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (op == OP_MUL);
  assign w_load      = (w_accept && (op != OP_MUL)) || w_mul_done;
  assign w_load_val  = w_mul_done ? w_mul_res : w_res;

  always_comb begin
    w_flags_nxt         = '0;
    w_flags_nxt[FLAG_Z] = (w_load_val == '0);
    w_flags_nxt[FLAG_N] = w_load_val[DW-1];
    w_flags_nxt[FLAG_C] = w_mul_done ? 1'b0 : w_cout;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_state_nxt = BUSY;
      BUSY:    if (w_mul_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output stage: a new result may replace one being drained in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_flags     <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_y         <= w_load_val;
      r_flags     <= w_flags_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign Y1        = r_y[DW-1:WIDTH];
  assign Y2        = r_y[WIDTH-1:0];
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=32 with hand-computed expected results.
module tb_alu_pipe;

  localparam int unsigned W = 32;

  localparam logic [2:0] T_ADD = 3'b000;
  localparam logic [2:0] T_SR  = 3'b001;
  localparam logic [2:0] T_AND = 3'b010;
  localparam logic [2:0] T_OR  = 3'b011;
  localparam logic [2:0] T_SUB = 3'b100;
  localparam logic [2:0] T_SL  = 3'b101;
  localparam logic [2:0] T_XOR = 3'b110;
  localparam logic [2:0] T_MUL = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         form;
  logic [1:0]   vec;
  logic [W-1:0] A, B, C, D;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y1, Y2;
  logic [2:0]   flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .form      (form),
    .vec       (vec),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y1        (Y1),
    .Y2        (Y2),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op, confirm it is accepted, return 1ns after the accepting edge.
  task automatic issue(input string tag, input logic [2:0] o, input logic f, input logic [1:0] v,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    op = o; form = f; vec = v; A = a; B = b; C = c; D = d;
    in_valid = 1'b1;
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] y1, input logic [W-1:0] y2,
                            input logic [2:0] fl);
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_y1"},  64'(Y1), 64'(y1));
    check({tag, "_y2"},  64'(Y2), 64'(y2));
    check({tag, "_flg"}, 64'(flags), 64'(fl));
  endtask

  task automatic op_1c(input string tag, input logic [2:0] o, input logic f, input logic [1:0] v,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [W-1:0] y1, input logic [W-1:0] y2, input logic [2:0] fl);
    issue(tag, o, f, v, a, b, c, d);
    expect_out(tag, y1, y2, fl);
  endtask

  task automatic run_mul(input string tag, input logic [1:0] v,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d, input int lw,
                         input logic [W-1:0] y1, input logic [W-1:0] y2, input logic [2:0] fl);
    int cyc;
    int rdy_hi;
    issue(tag, T_MUL, 1'b0, v, a, b, c, d);
    cyc = 0;
    rdy_hi = 0;
    while (!out_valid && cyc < 4 * lw + 4) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lw));
    check({tag, "_busy_rdy"}, 64'(rdy_hi), 64'd0);
    expect_out(tag, y1, y2, fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; form = 1'b0; vec = '0; A = '0; B = '0; C = '0; D = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_y1", 64'(Y1), 64'd0);
    check("rst_y2", 64'(Y2), 64'd0);
    check("rst_flg", 64'(flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", 64'(in_ready), 64'd1);

    op_1c("full_add", T_ADD, 1'b0, 2'b10, 32'hFFFFFFFF, 32'h2, 32'h1, 32'h3, 32'h0, 32'h5, 3'b100);
    @(posedge clk); #1;
    check("drain_vld", 64'(out_valid), 64'd0);

    // Back-to-back single-cycle ops
    op_1c("char_add", T_ADD, 1'b0, 2'b00, 32'h01FF7F80, 32'h0, 32'h01010101, 32'h0, 32'h02008081, 32'h0, 3'b000);
    op_1c("dbl_sub",  T_SUB, 1'b0, 2'b11, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110);
    op_1c("half_sub", T_SUB, 1'b0, 2'b01, 32'h00050000, 32'h0, 32'h00010001, 32'h0, 32'h0004FFFF, 32'h0, 3'b000);
    op_1c("char_sub", T_SUB, 1'b0, 2'b00, 32'h0, 32'h0, 32'h01000000, 32'h0, 32'hFF000000, 32'h0, 3'b110);
    op_1c("half_add", T_ADD, 1'b0, 2'b01, 32'hFFFF0001, 32'h0, 32'h00010001, 32'h0, 32'h00000002, 32'h0, 3'b100);
    op_1c("dbl_add",  T_ADD, 1'b0, 2'b11, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1, 32'h0, 3'b000);
    op_1c("char_sra", T_SR,  1'b1, 2'b00, 32'h80F00810, 32'h0, 32'h01020304, 32'h0, 32'hC0FC0101, 32'h0, 3'b010);
    op_1c("char_srl", T_SR,  1'b0, 2'b00, 32'h80F00810, 32'h0, 32'h01020304, 32'h0, 32'h403C0101, 32'h0, 3'b000);
    op_1c("full_sl",  T_SL,  1'b0, 2'b10, 32'h1, 32'h1, 32'h1F, 32'h20, 32'h80000000, 32'h1, 3'b010);
    op_1c("dbl_srl",  T_SR,  1'b0, 2'b11, 32'h80000000, 32'h0, 32'h0, 32'h21, 32'h0, 32'h40000000, 3'b000);
    op_1c("dbl_sl",   T_SL,  1'b0, 2'b11, 32'h0, 32'h1, 32'h0, 32'h3F, 32'h80000000, 32'h0, 3'b010);
    op_1c("xor",      T_XOR, 1'b0, 2'b00, 32'hFF00FF00, 32'h12345678, 32'h0F0F0F0F, 32'h12345678, 32'hF00FF00F, 32'h0, 3'b010);
    op_1c("and_zero", T_AND, 1'b0, 2'b01, 32'hFFFF0000, 32'h1, 32'h0000FFFF, 32'h2, 32'h0, 32'h0, 3'b001);
    op_1c("or",       T_OR,  1'b0, 2'b10, 32'h00F0000F, 32'h0, 32'h0F000F00, 32'h80000000, 32'h0FF00F0F, 32'h80000000, 3'b000);

    // Multiplier in every lane mode
    run_mul("half_mul", 2'b01, 32'h00030004, 32'h0, 32'h00050006, 32'h0, 16, 32'h000F0018, 32'h0, 3'b000);
    run_mul("char_mul", 2'b00, 32'hFF100203, 32'h2, 32'hFF100304, 32'h3, 8, 32'h0100060C, 32'h6, 3'b000);
    run_mul("full_mul", 2'b10, 32'h0000FFFF, 32'h7, 32'h00010001, 32'h9, 32, 32'hFFFFFFFF, 32'h3F, 3'b010);
    run_mul("dbl_mul",  2'b11, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 64, 32'h1, 32'h0, 3'b000);

    // Backpressure: first result held, second op waits until the consumer drains
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("bp_add", T_ADD, 1'b0, 2'b10, 32'h1, 32'h3, 32'h2, 32'h4);
    expect_out("bp_add", 32'h3, 32'h7, 3'b000);
    op = T_XOR; form = 1'b0; vec = 2'b10;
    A = 32'hF0F0F0F0; B = 32'hAAAAAAAA; C = 32'h0F0F0F0F; D = 32'hAAAAAAAA;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_y1", 64'(Y1), 64'h3);
      check("bp_hold_y2", 64'(Y2), 64'h7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 check("bp_rel_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("bp_xor", 32'hFFFFFFFF, 32'h0, 3'b010);
    @(posedge clk); #1;
    check("bp_drain_vld", 64'(out_valid), 64'd0);

    // Reset during MUL iteration 5, then a fresh full-length MUL
    op_1c("pre_add", T_ADD, 1'b0, 2'b10, 32'h11111111, 32'h22222222, 32'h1, 32'h1, 32'h11111112, 32'h22222223, 3'b000);
    issue("rst_mul", T_MUL, 1'b0, 2'b01, 32'h00070009, 32'h0, 32'h00030002, 32'h0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_vld", 64'(out_valid), 64'd0);
    check("rst_mid_y1", 64'(Y1), 64'd0);
    check("rst_mid_y2", 64'(Y2), 64'd0);
    check("rst_mid_flg", 64'(flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rdy", 64'(in_ready), 64'd1);
    run_mul("post_rst_mul", 2'b01, 32'h00070009, 32'h0, 32'h00030002, 32'h0, 16, 32'h00150012, 32'h0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
